// File: rtl/booth_radix4_seq_multiplier.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock, signed or
// unsigned operands, start/busy/done handshake.
// Optional build macro BOOTH_RADIX4_OVF_EN adds the ovf output, which flags
// products that do not fit in WIDTH bits for the captured mode.
//
// state | meaning
// IDLE  | waiting for start; result (and ovf) hold the last product
// RUN   | one Booth digit retired per clock; cnt counts digits still to go
// DONE  | one-cycle completion pulse; start is accepted here exactly as in IDLE
module booth_radix4_seq_multiplier #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     op1,
   input  logic [WIDTH-1:0]     op2,
   output logic                 busy,
   output logic                 done,
`ifdef BOOTH_RADIX4_OVF_EN
   output logic                 ovf,
`endif
   output logic [2*WIDTH-1:0]   result
);

   // Operands are extended by two bits so both signed and unsigned inputs
   // can be handled as signed values by the same Booth recoder.
   localparam int XW = WIDTH + 2;
   localparam int PW = 2 * XW + 1;
   localparam int N  = WIDTH / 2 + 1;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       p_q, p_d;
   logic [XW-1:0]       m_q, m_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2*WIDTH-1:0]  result_q, result_d;
`ifdef BOOTH_RADIX4_OVF_EN
   logic                mode_q, mode_d;
   logic                ovf_q, ovf_d;
   logic [WIDTH:0]      prod_hi_s;
   logic                ovf_calc;
`endif

   logic [XW-1:0]       op1_ext;
   logic [XW-1:0]       op2_ext;
   logic [XW-1:0]       acc;
   logic [XW-1:0]       mul_field;
   logic [XW:0]         m_wide;
   logic [XW:0]         m_dbl;
   logic [XW:0]         pp;
   logic [XW:0]         sum;
   logic [PW-1:0]       p_step;
   logic [2*WIDTH-1:0]  prod_lo;

   // Operand extension selected by the mode presented with start.
   always_comb begin
      op1_ext = signed_mode ? {{2{op1[WIDTH-1]}}, op1} : {2'b00, op1};
      op2_ext = signed_mode ? {{2{op2[WIDTH-1]}}, op2} : {2'b00, op2};
   end

   // One Booth step: add selected partial product to the upper half, shift right by 2.
   always_comb begin
      acc       = p_q[PW-1:XW+1];
      mul_field = p_q[XW:1];
      m_wide    = {m_q[XW-1], m_q};
      m_dbl     = {m_q, 1'b0};
      pp        = '0;
      unique case (p_q[2:0])
         3'b001, 3'b010: pp = m_wide;
         3'b011:         pp = m_dbl;
         3'b100:         pp = -m_dbl;
         3'b101, 3'b110: pp = -m_wide;
         default:        pp = '0;
      endcase
      // sum needs one bit more than acc; the shift brings it back into range.
      sum     = {acc[XW-1], acc} + pp;
      p_step  = {sum[XW], sum, mul_field[XW-1:1]};
      prod_lo = p_step[2*WIDTH:1];
   end

`ifdef BOOTH_RADIX4_OVF_EN
   // Overflow of the product being written, judged in the captured mode.
   always_comb begin
      prod_hi_s = prod_lo[2*WIDTH-1:WIDTH-1];
      if (mode_q) begin
         ovf_calc = !((&prod_hi_s) || !(|prod_hi_s));
      end else begin
         ovf_calc = |prod_lo[2*WIDTH-1:WIDTH];
      end
   end
`endif

   // Next-state and register updates for the handshake FSM.
   always_comb begin
      state_d  = state_q;
      p_d      = p_q;
      m_d      = m_q;
      cnt_d    = cnt_q;
      result_d = result_q;
`ifdef BOOTH_RADIX4_OVF_EN
      mode_d   = mode_q;
      ovf_d    = ovf_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               m_d     = op1_ext;
               p_d     = {{XW{1'b0}}, op2_ext, 1'b0};
               cnt_d   = CW'(N);
               state_d = RUN;
`ifdef BOOTH_RADIX4_OVF_EN
               mode_d  = signed_mode;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            p_d   = p_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               result_d = prod_lo;
               state_d  = DONE;
`ifdef BOOTH_RADIX4_OVF_EN
               ovf_d    = ovf_calc;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         p_q      <= '0;
         m_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
`ifdef BOOTH_RADIX4_OVF_EN
         mode_q   <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         p_q      <= p_d;
         m_q      <= m_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
`ifdef BOOTH_RADIX4_OVF_EN
         mode_q   <= mode_d;
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);
   assign result = result_q;
`ifdef BOOTH_RADIX4_OVF_EN
   assign ovf    = ovf_q;
`endif

endmodule
